// File: rtl/fetch_unit.sv
// Instruction fetch front end for the RV32I core.
// Owns the PC, issues word requests over a req/gnt/rvalid interface with at
// most one request in flight, and buffers returned words in a 2-entry
// in-order buffer (output register + pending register) behind a valid/ready
// handshake. Redirects arrive with an accepted instruction via PC_sel.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   imem_req/addr/gnt            request channel (addr held until gnt)
//   imem_rvalid/rdata            in-order response channel
//   instr_valid/ready            instruction handshake
//   instr, instr_pc              current instruction word and its address
//   opcode, funct3, funct7b5     decode fields sliced from instr
//   PC_sel, pc_target            redirect request and target, used on accept
//   misaligned_err               sticky flag for a non-word-aligned redirect
module fetch_unit #(
    parameter int unsigned        XLEN     = 32,
    parameter logic [XLEN-1:0]    RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic            funct7b5,
    input  logic            PC_sel,
    input  logic [XLEN-1:0] pc_target,
    output logic            misaligned_err
);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_word_q, out_word_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic            pend_valid_q, pend_valid_d;
    logic [XLEN-1:0] pend_word_q, pend_word_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            outstanding_q, outstanding_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic            discard_q, discard_d;
    logic            hold_q, hold_d;
    logic [XLEN-1:0] hold_addr_q, hold_addr_d;
    logic            hold_stale_q, hold_stale_d;
    logic            misaligned_q, misaligned_d;

    logic            accept_c;
    logic            redirect_c;
    logic            grant_c;
    logic            rsp_c;
    logic            rsp_keep_c;
    logic [1:0]      occ_after_c;
    logic [1:0]      owed_c;
    logic            can_issue_c;
    logic            req_c;
    logic [XLEN-1:0] req_addr_c;

    // Handshake decode and issue decision
    always_comb begin
        accept_c    = out_valid_q && instr_ready;
        redirect_c  = accept_c && PC_sel;
        rsp_c       = imem_rvalid && outstanding_q;
        // A response racing a redirect belongs to the old stream.
        rsp_keep_c  = rsp_c && !discard_q && !redirect_c && !misaligned_q;
        occ_after_c = 2'(out_valid_q) + 2'(pend_valid_q) - 2'(accept_c);
        // A returning word moves from "owed" to "buffered", so counting the
        // outstanding request before rvalid keeps room for it.
        owed_c      = occ_after_c + 2'(outstanding_q);
        // No fresh issue on a redirect cycle: fetch_pc still holds the old stream.
        can_issue_c = !misaligned_q && !redirect_c
                      && (!outstanding_q || imem_rvalid)
                      && (owed_c < 2'd2);
        req_c       = hold_q || can_issue_c;
        req_addr_c  = hold_q ? hold_addr_q : fetch_pc_q;
        grant_c     = req_c && imem_gnt;
    end

    assign imem_req  = req_c && !reset;
    assign imem_addr = reset ? '0 : req_addr_c;

    // Next-state logic
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        out_valid_d   = out_valid_q;
        out_word_d    = out_word_q;
        out_pc_d      = out_pc_q;
        pend_valid_d  = pend_valid_q;
        pend_word_d   = pend_word_q;
        pend_pc_d     = pend_pc_q;
        outstanding_d = outstanding_q;
        rsp_pc_d      = rsp_pc_q;
        discard_d     = discard_q;
        hold_d        = req_c && !imem_gnt;
        hold_addr_d   = req_addr_c;
        hold_stale_d  = req_c && !imem_gnt && (hold_stale_q || redirect_c);
        misaligned_d  = misaligned_q || (redirect_c && (pc_target[1:0] != 2'b00));

        // A stale held request must not advance the redirected fetch_pc.
        if (redirect_c) begin
            fetch_pc_d = pc_target;
        end else if (grant_c && !hold_stale_q) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        if (grant_c) begin
            outstanding_d = 1'b1;
            rsp_pc_d      = req_addr_c;
            discard_d     = hold_stale_q || redirect_c;
        end else if (redirect_c && outstanding_q && !imem_rvalid) begin
            discard_d     = 1'b1;
        end else if (rsp_c) begin
            outstanding_d = 1'b0;
            discard_d     = 1'b0;
        end

        // 2-entry in-order buffer
        if (redirect_c) begin
            out_valid_d  = 1'b0;
            pend_valid_d = 1'b0;
        end else if (accept_c) begin
            if (pend_valid_q) begin
                out_valid_d  = 1'b1;
                out_word_d   = pend_word_q;
                out_pc_d     = pend_pc_q;
                pend_valid_d = rsp_keep_c;
                pend_word_d  = imem_rdata;
                pend_pc_d    = rsp_pc_q;
            end else begin
                out_valid_d  = rsp_keep_c;
                out_word_d   = imem_rdata;
                out_pc_d     = rsp_pc_q;
            end
        end else if (!out_valid_q) begin
            out_valid_d = rsp_keep_c;
            out_word_d  = imem_rdata;
            out_pc_d    = rsp_pc_q;
        end else if (rsp_keep_c) begin
            pend_valid_d = 1'b1;
            pend_word_d  = imem_rdata;
            pend_pc_d    = rsp_pc_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            out_valid_q   <= 1'b0;
            out_word_q    <= '0;
            out_pc_q      <= '0;
            pend_valid_q  <= 1'b0;
            pend_word_q   <= '0;
            pend_pc_q     <= '0;
            outstanding_q <= 1'b0;
            rsp_pc_q      <= '0;
            discard_q     <= 1'b0;
            hold_q        <= 1'b0;
            hold_addr_q   <= '0;
            hold_stale_q  <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            out_valid_q   <= out_valid_d;
            out_word_q    <= out_word_d;
            out_pc_q      <= out_pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_word_q   <= pend_word_d;
            pend_pc_q     <= pend_pc_d;
            outstanding_q <= outstanding_d;
            rsp_pc_q      <= rsp_pc_d;
            discard_q     <= discard_d;
            hold_q        <= hold_d;
            hold_addr_q   <= hold_addr_d;
            hold_stale_q  <= hold_stale_d;
            misaligned_q  <= misaligned_d;
        end
    end

    assign instr_valid    = out_valid_q;
    assign instr          = out_word_q;
    assign instr_pc       = out_pc_q;
    assign misaligned_err = misaligned_q;
    assign opcode         = out_word_q[6:0];
    assign funct3         = out_word_q[14:12];
    assign funct7b5       = out_word_q[30];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small memory responder answers each grant
// after a programmable latency; the main sequence steps cycle by cycle and
// compares DUT outputs against hand-computed values.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        PC_sel;
    logic [31:0] pc_target;
    logic        misaligned_err;

    int n_checks = 0;
    int n_fail   = 0;
    int ngrant   = 0;
    int lat      = 1;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7b5       (funct7b5),
        .PC_sel         (PC_sel),
        .pc_target      (pc_target),
        .misaligned_err (misaligned_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word stored at an address: addi x1,x0,5 with the address folded into the immediate.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h0050_0093 ^ {a[11:0], 20'h0};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Memory responder: one response per grant, lat cycles later.
    initial begin : mem
        logic        g;
        logic [31:0] ga;
        logic [31:0] ra;
        int          cnt;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        g   = 1'b0;
        ga  = '0;
        ra  = '0;
        cnt = 0;
        forever begin
            @(negedge clk);
            g  = imem_req && imem_gnt;
            ga = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (g) begin
                ra  = ga;
                cnt = lat;
                ngrant++;
            end
            if (cnt != 0) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word_at(ra);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        imem_gnt    = 1'b0;
        instr_ready = 1'b0;
        PC_sel      = 1'b0;
        pc_target   = '0;
        #2;
        check_eq("rst_req",   32'(imem_req), 32'd0);
        check_eq("rst_addr",  imem_addr, 32'h0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_mis",   32'(misaligned_err), 32'd0);
        adv(); adv();

        // Startup + backpressure
        reset    = 1'b0;
        imem_gnt = 1'b1;
        smp();
        check_eq("start_req",  32'(imem_req), 32'd1);
        check_eq("start_addr", imem_addr, 32'h0);
        adv(); smp();
        check_eq("second_addr", imem_addr, 32'h4);
        check_eq("second_req",  32'(imem_req), 32'd1);
        adv(); smp();
        check_eq("first_valid",  32'(instr_valid), 32'd1);
        check_eq("first_pc",     instr_pc, 32'h0);
        check_eq("first_instr",  instr, 32'h0050_0093);
        check_eq("first_opcode", 32'(opcode), 32'h13);
        check_eq("first_funct3", 32'(funct3), 32'd0);
        check_eq("first_f7b5",   32'(funct7b5), 32'd0);
        check_eq("bp_noreq",     32'(imem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            adv(); smp();
            check_eq("bp_hold_req", 32'(imem_req), 32'd0);
            check_eq("bp_hold_pc",  instr_pc, 32'h0);
        end
        check_eq("bp_grants", 32'(ngrant), 32'd2);

        adv(); instr_ready = 1'b1; smp();
        check_eq("drain_pc0",   instr_pc, 32'h0);
        check_eq("resume_req",  32'(imem_req), 32'd1);
        check_eq("resume_addr", imem_addr, 32'h8);
        adv(); smp();
        check_eq("drain_pc4",    instr_pc, 32'h4);
        check_eq("drain_instr4", instr, word_at(32'h4));

        // Redirect to 0x40 while the 0xC response is in flight
        adv(); PC_sel = 1'b1; pc_target = 32'h40; smp();
        check_eq("redir_pc8",  instr_pc, 32'h8);
        check_eq("redir_noreq", 32'(imem_req), 32'd0);
        adv(); PC_sel = 1'b0; smp();
        check_eq("redir_drop", 32'(instr_valid), 32'd0);
        check_eq("redir_req",  32'(imem_req), 32'd1);
        check_eq("redir_addr", imem_addr, 32'h40);
        adv(); smp();
        check_eq("redir_gap",   32'(instr_valid), 32'd0);
        check_eq("redir_addr2", imem_addr, 32'h44);
        adv(); smp();
        check_eq("new_pc40",  instr_pc, 32'h40);
        check_eq("new_instr", instr, word_at(32'h40));
        adv(); smp();
        check_eq("stream_v44",  32'(instr_valid), 32'd1);
        check_eq("stream_pc44", instr_pc, 32'h44);

        // Redirect to 0x10 with grants withheld
        adv(); PC_sel = 1'b1; pc_target = 32'h10; imem_gnt = 1'b0; smp();
        check_eq("stream_v48",  32'(instr_valid), 32'd1);
        check_eq("stream_pc48", instr_pc, 32'h48);
        adv(); PC_sel = 1'b0; smp();
        check_eq("stall_drop", 32'(instr_valid), 32'd0);
        check_eq("stall_req",  32'(imem_req), 32'd1);
        check_eq("stall_addr", imem_addr, 32'h10);
        for (int i = 0; i < 2; i++) begin
            adv(); smp();
            check_eq("stall_hold_req",  32'(imem_req), 32'd1);
            check_eq("stall_hold_addr", imem_addr, 32'h10);
        end
        adv(); imem_gnt = 1'b1; smp();
        check_eq("gnt_addr", imem_addr, 32'h10);
        adv(); smp();
        check_eq("post_gnt_addr", imem_addr, 32'h14);
        check_eq("post_gnt_req",  32'(imem_req), 32'd1);

        // Misaligned redirect
        adv(); PC_sel = 1'b1; pc_target = 32'h42; smp();
        check_eq("mis_pc10",  instr_pc, 32'h10);
        check_eq("mis_before", 32'(misaligned_err), 32'd0);
        adv(); PC_sel = 1'b0; smp();
        check_eq("mis_set",   32'(misaligned_err), 32'd1);
        check_eq("mis_req",   32'(imem_req), 32'd0);
        check_eq("mis_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            adv(); smp();
            check_eq("mis_hold_req",   32'(imem_req), 32'd0);
            check_eq("mis_hold_valid", 32'(instr_valid), 32'd0);
            check_eq("mis_sticky",     32'(misaligned_err), 32'd1);
        end

        // Reset clears the sticky error; then reset while a request is outstanding
        adv(); reset = 1'b1; imem_gnt = 1'b0; instr_ready = 1'b0; lat = 3;
        #1;
        check_eq("mis_cleared", 32'(misaligned_err), 32'd0);
        adv(); reset = 1'b0; imem_gnt = 1'b1; smp();
        check_eq("rs_req0",  32'(imem_req), 32'd1);
        check_eq("rs_addr0", imem_addr, 32'h0);
        adv(); smp();
        check_eq("rs_wait1", 32'(imem_req), 32'd0);
        adv(); smp();
        check_eq("rs_wait2", 32'(imem_req), 32'd0);
        adv(); smp();
        check_eq("rs_req4",  32'(imem_req), 32'd1);
        check_eq("rs_addr4", imem_addr, 32'h4);
        adv(); imem_gnt = 1'b0; smp();
        check_eq("rs_valid",  32'(instr_valid), 32'd1);
        check_eq("rs_instr",  instr, 32'h0050_0093);
        check_eq("rs_addr8",  imem_addr, 32'h8);
        #1 reset = 1'b1;
        #1;
        check_eq("rs_now_valid", 32'(instr_valid), 32'd0);
        check_eq("rs_now_instr", instr, 32'h0);
        check_eq("rs_now_pc",    instr_pc, 32'h0);
        check_eq("rs_now_addr",  imem_addr, 32'h0);
        check_eq("rs_now_req",   32'(imem_req), 32'd0);
        adv(); reset = 1'b0; smp();
        check_eq("rel_req",  32'(imem_req), 32'd1);
        check_eq("rel_addr", imem_addr, 32'h0);
        adv(); smp();
        check_eq("late_rsp_cycle", 32'(instr_valid), 32'd0);
        adv(); smp();
        check_eq("late_ignored", 32'(instr_valid), 32'd0);
        check_eq("late_addr",    imem_addr, 32'h0);
        adv(); imem_gnt = 1'b1; lat = 1; smp();
        check_eq("refetch_valid0", 32'(instr_valid), 32'd0);
        check_eq("refetch_addr",   imem_addr, 32'h0);
        adv(); smp();
        adv(); smp();
        check_eq("refetch_valid", 32'(instr_valid), 32'd1);
        check_eq("refetch_pc",    instr_pc, 32'h0);
        check_eq("refetch_instr", instr, 32'h0050_0093);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
